cmd_change_fifo: RTL and testbench
==================================

Name: cmd_change_fifo

Overview:
- Sits directly downstream of the per-command debounce filter bank.
- Takes the filtered command vector and detects level changes on every bit.
- Turns each change into an event {index, new level} and queues events in a small FIFO.
- Delivers events to the consumer (command processor / event log) over a valid/ready handshake, one event per cycle.

Parameters:
- NUM_SIGNALS, 16, number of command bits, 2..64.
- FIFO_DEPTH, 8, event FIFO entries, power of 2, >= 2.
- IDX_WIDTH, $clog2(NUM_SIGNALS), derived localparam; not overridable.

Ports:
- clk  in  1  clock, all logic on rising edge.
- aclr_n  in  1  reset: synchronous, active-low; sampled on clk rising edge only.
- in  in  NUM_SIGNALS  filtered command levels.
- state  out  NUM_SIGNALS  registered copy of in (prev register).
- ev_valid  out  1  FIFO head holds an event.
- ev_ready  in  1  consumer accepts head this cycle.
- ev_index  out  IDX_WIDTH  bit index of head event.
- ev_level  out  1  level of that bit when the event was queued.
- count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy, 0..FIFO_DEPTH.
- merged  out  1  sticky: a change occurred on a bit already pending.
- clr_merged  in  1  clears merged; synchronous, one cycle.

Behaviour:
- Reset (aclr_n=0 at an edge):
  - prev, pending, FIFO pointers, count and merged all go to 0.
  - init flag is set.
  - Outputs are then: state=0, ev_valid=0, ev_index=0, ev_level=0, count=0, merged=0.
- First edge after reset release (init=1):
  - prev <= in; init clears.
  - No change detection, so no events for levels already present at startup.
- Change detection, each later edge k:
  - change = in ^ prev; prev <= in.
  - pending[i] <= (pending[i] & ~served[i]) | change[i].
- Merge: if change[i]=1 while pending[i]=1 and bit i is not served this edge, merged <= 1.
- merged priority: a set condition wins over clr_merged in the same cycle.
- Serializer, each edge:
  - If pending != 0 and the FIFO is not full, select the lowest set pending index j.
  - Push {j, prev[j]}, i.e. the level as held in prev before this edge updates it.
  - Set served[j]=1; all other served bits are 0.
  - If j also changes on this same edge, pending[j] stays 1, because the change term wins over the clear.
- Latency: a change sampled at edge k is pushed at edge k+1 at the earliest, so ev_valid is high after edge k+1.
- Multiple simultaneous changes are pushed one per cycle in ascending index order.
- Pending bits are never lost. A full FIFO only stalls the serializer.
- A bit toggled twice before service produces one event, carrying its level at service time.
- FIFO behaviour:
  - First-word-fall-through; ev_index/ev_level are driven from the head entry, registered storage.
  - ev_valid = (count != 0).
  - Pop when ev_valid & ev_ready.
  - Push allowed when count < FIFO_DEPTH at the start of the cycle.
  - Push and pop in the same cycle: count unchanged, both applied.
  - Full and popping: push is not allowed that cycle; it is allowed next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - ev_ready while empty: ignored.
  - When ev_valid=0, ev_index/ev_level are don't-care; the bench must not check them.
- Reset mid-operation: discards all queued and pending events next edge; merged clears. The first edge after release re-runs init, so no events are generated.

Test Plan:
1. aclr_n=0, in=16'hFFFF, then release, ev_ready=1, hold 10 cycles -> state=16'hFFFF, ev_valid stays 0, count=0, merged=0.
2. After init, in bit3 0->1 sampled at edge k -> ev_valid=1 after edge k+1, ev_index=3, ev_level=1; pop -> count=0.
3. in 16'h0000->16'h0011 in one cycle, ev_ready=1 -> events (0,1) then (4,1) on consecutive cycles; count never exceeds 1.
4. ev_ready=0, bits 0..9 rise together -> count saturates at 8, pending holds bits 8,9, merged=0; set ev_ready=1 -> 10 events, indices 0..9 in order, all level 1.
5. FIFO full, ev_ready=0, bit5 rises then falls while pending -> merged=1; after drain, one event idx5 level 0. clr_merged=1 -> merged=0. Set and clear in the same cycle -> merged stays 1.
6. count=5 with pending bits set, aclr_n=0 one cycle -> next cycle count=0, ev_valid=0, merged=0; no events after release despite in being nonzero.

Source files
------------

// File: rtl/cmd_change_fifo.sv
// Purpose: detects level changes on the filtered command vector and queues {index, level} events.
// Latency: a change sampled at edge k reaches the FIFO head at edge k+1 at the earliest.
// Backpressure: ev_ready low stalls pops; a full FIFO stalls the serializer and changes wait as pending bits.
module cmd_change_fifo #(
    parameter int NUM_SIGNALS = 16,
    parameter int FIFO_DEPTH  = 8,
    localparam int IDX_WIDTH  = $clog2(NUM_SIGNALS),
    localparam int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1,
    localparam int PTR_WIDTH  = $clog2(FIFO_DEPTH)
) (
    input  logic                   clk,
    input  logic                   aclr_n,
    input  logic [NUM_SIGNALS-1:0] in,
    output logic [NUM_SIGNALS-1:0] state,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [IDX_WIDTH-1:0]   ev_index,
    output logic                   ev_level,
    output logic [CNT_WIDTH-1:0]   count,
    output logic                   merged,
    input  logic                   clr_merged
);

    typedef struct packed {
        logic [IDX_WIDTH-1:0] index;
        logic                 level;
    } ev_t;

    logic [NUM_SIGNALS-1:0] prev_q, prev_d;
    logic [NUM_SIGNALS-1:0] pending_q, pending_d;
    logic                   init_q, init_d;
    logic                   merged_q, merged_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    ev_t                    mem_q [FIFO_DEPTH];
    ev_t                    mem_d [FIFO_DEPTH];

    logic [NUM_SIGNALS-1:0] change;
    logic [NUM_SIGNALS-1:0] served;
    logic [IDX_WIDTH-1:0]   sel_idx;
    logic                   push;
    logic                   pop;

    always_comb begin
        change  = init_q ? '0 : (in ^ prev_q);
        sel_idx = '0;
        // Descending scan so the lowest set pending bit is the one left selected.
        for (int i = NUM_SIGNALS - 1; i >= 0; i--) begin
            if (pending_q[i]) sel_idx = IDX_WIDTH'(i);
        end
        push   = (|pending_q) && (count_q < CNT_WIDTH'(FIFO_DEPTH));
        pop    = (count_q != '0) && ev_ready;
        served = push ? (NUM_SIGNALS'(1) << sel_idx) : '0;

        prev_d    = in;
        init_d    = 1'b0;
        pending_d = (pending_q & ~served) | change;
        if (|(change & pending_q & ~served)) merged_d = 1'b1;
        else if (clr_merged)                 merged_d = 1'b0;
        else                                 merged_d = merged_q;

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = '{index: sel_idx, level: prev_q[sel_idx]};
        wr_ptr_d = wr_ptr_q + PTR_WIDTH'(push);
        rd_ptr_d = rd_ptr_q + PTR_WIDTH'(pop);
        count_d  = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    end

    always_ff @(posedge clk) begin
        if (!aclr_n) begin
            prev_q    <= '0;
            pending_q <= '0;
            init_q    <= 1'b1;
            merged_q  <= 1'b0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            prev_q    <= prev_d;
            pending_q <= pending_d;
            init_q    <= init_d;
            merged_q  <= merged_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign state    = prev_q;
    assign ev_valid = (count_q != '0);
    assign ev_index = mem_q[rd_ptr_q].index;
    assign ev_level = mem_q[rd_ptr_q].level;
    assign count    = count_q;
    assign merged   = merged_q;

endmodule

// File: tb/tb_cmd_change_fifo.sv
// Directed bench for cmd_change_fifo: startup, latency, ordering, saturation, merge and reset cases.
module tb_cmd_change_fifo;
    localparam int N = 16;
    localparam int D = 8;

    logic          clk = 1'b0;
    logic          aclr_n = 1'b0;
    logic [N-1:0]  in_v = '0;
    logic [N-1:0]  state;
    logic          ev_valid;
    logic          ev_ready = 1'b0;
    logic [3:0]    ev_index;
    logic          ev_level;
    logic [3:0]    count;
    logic          merged;
    logic          clr_merged = 1'b0;

    cmd_change_fifo #(.NUM_SIGNALS(N), .FIFO_DEPTH(D)) dut (
        .clk(clk), .aclr_n(aclr_n), .in(in_v), .state(state),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_index(ev_index),
        .ev_level(ev_level), .count(count), .merged(merged), .clr_merged(clr_merged)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int got_idx[$];
    int got_lvl[$];
    int got_cyc[$];
    int max_cnt;
    logic saw;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [N-1:0] v);
        in_v = v;
        aclr_n = 1'b0;
        tick();
        aclr_n = 1'b1;
        tick();
        tick();
    endtask

    // Records every head that is popped at the following edge.
    task automatic drain(input int cycles);
        got_idx.delete();
        got_lvl.delete();
        got_cyc.delete();
        max_cnt = 0;
        ev_ready = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            if (ev_valid) begin
                got_idx.push_back(int'(ev_index));
                got_lvl.push_back(int'(ev_level));
                got_cyc.push_back(c);
            end
            if (int'(count) > max_cnt) max_cnt = int'(count);
            tick();
        end
        ev_ready = 1'b0;
    endtask

    int exp5 [9] = '{0, 1, 2, 3, 4, 6, 7, 8, 5};

    initial begin
        // 1: reset values, then no startup events
        in_v = 16'hFFFF;
        tick();
        tick();
        check("rst_state", state, 0);
        check("rst_valid", ev_valid, 0);
        check("rst_count", count, 0);
        check("rst_merged", merged, 0);
        check("rst_index", ev_index, 0);
        check("rst_level", ev_level, 0);
        aclr_n = 1'b1;
        ev_ready = 1'b1;
        saw = 1'b0;
        repeat (10) begin
            tick();
            if (ev_valid) saw = 1'b1;
        end
        ev_ready = 1'b0;
        check("t1_state", state, 16'hFFFF);
        check("t1_no_events", saw, 0);
        check("t1_count", count, 0);
        check("t1_merged", merged, 0);

        // 2: single rise, one-cycle latency
        do_reset('0);
        in_v[3] = 1'b1;
        tick();
        check("t2_valid_k", ev_valid, 0);
        tick();
        check("t2_valid_k1", ev_valid, 1);
        check("t2_index", ev_index, 3);
        check("t2_level", ev_level, 1);
        check("t2_count", count, 1);
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        check("t2_count_pop", count, 0);
        check("t2_valid_pop", ev_valid, 0);

        // 3: two simultaneous changes, ascending order on consecutive cycles
        do_reset('0);
        in_v = 16'h0011;
        drain(8);
        check("t3_n", got_idx.size(), 2);
        if (got_idx.size() == 2) begin
            check("t3_idx0", got_idx[0], 0);
            check("t3_lvl0", got_lvl[0], 1);
            check("t3_idx1", got_idx[1], 4);
            check("t3_lvl1", got_lvl[1], 1);
            check("t3_consec", got_cyc[1] - got_cyc[0], 1);
        end
        check("t3_maxcnt", max_cnt, 1);

        // 4: saturation with pending overflow
        do_reset('0);
        in_v = 16'h03FF;
        repeat (12) tick();
        check("t4_count", count, 8);
        check("t4_merged", merged, 0);
        drain(20);
        check("t4_n", got_idx.size(), 10);
        for (int i = 0; i < got_idx.size() && i < 10; i++) begin
            check($sformatf("t4_idx%0d", i), got_idx[i], i);
            check($sformatf("t4_lvl%0d", i), got_lvl[i], 1);
        end

        // 5: merge while full, clear, set-vs-clear priority
        do_reset('0);
        in_v = 16'h01DF;
        repeat (12) tick();
        check("t5_full", count, 8);
        in_v[5] = 1'b1;
        tick();
        check("t5_merged_pre", merged, 0);
        in_v[5] = 1'b0;
        tick();
        check("t5_merged", merged, 1);
        drain(20);
        check("t5_n", got_idx.size(), 9);
        for (int i = 0; i < got_idx.size() && i < 9; i++) begin
            check($sformatf("t5_idx%0d", i), got_idx[i], exp5[i]);
            check($sformatf("t5_lvl%0d", i), got_lvl[i], (i == 8) ? 0 : 1);
        end
        check("t5_merged_sticky", merged, 1);
        clr_merged = 1'b1;
        tick();
        clr_merged = 1'b0;
        check("t5_clr", merged, 0);
        in_v = in_v ^ 16'h0C00;
        tick();
        in_v[11] = ~in_v[11];
        clr_merged = 1'b1;
        tick();
        clr_merged = 1'b0;
        check("t5_set_wins", merged, 1);
        drain(8);
        check("t5b_n", got_idx.size(), 2);
        if (got_idx.size() == 2) begin
            check("t5b_idx0", got_idx[0], 10);
            check("t5b_lvl0", got_lvl[0], 1);
            check("t5b_idx1", got_idx[1], 11);
            check("t5b_lvl1", got_lvl[1], 0);
        end

        // 6: reset mid-operation discards queue, pending and merged
        do_reset('0);
        in_v = 16'h007F;
        tick();
        in_v[6] = 1'b0;
        tick();
        repeat (4) tick();
        check("t6_count", count, 5);
        check("t6_merged", merged, 1);
        aclr_n = 1'b0;
        tick();
        check("t6_rst_count", count, 0);
        check("t6_rst_valid", ev_valid, 0);
        check("t6_rst_merged", merged, 0);
        check("t6_rst_state", state, 0);
        aclr_n = 1'b1;
        ev_ready = 1'b1;
        saw = 1'b0;
        repeat (10) begin
            tick();
            if (ev_valid) saw = 1'b1;
        end
        ev_ready = 1'b0;
        check("t6_no_events", saw, 0);
        check("t6_state", state, 16'h003F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
